// File: rtl/pin_verifier.sv
// Keypad front end: collects a 4-digit account then a 4-digit PIN, checks both against a parameter table, and locks out after repeated bad PINs.
// Latency: 1 cycle from any strobe to registered outputs; backpressure: none, every strobe is consumed or dropped in its own cycle.
module pin_verifier #(
  parameter logic [15:0] ACCT0       = 16'h1234,
  parameter logic [15:0] ACCT1       = 16'h2345,
  parameter logic [15:0] ACCT2       = 16'h3456,
  parameter logic [15:0] ACCT3       = 16'h4567,
  parameter logic [15:0] PIN0        = 16'h1111,
  parameter logic [15:0] PIN1        = 16'h2222,
  parameter logic [15:0] PIN2        = 16'h3333,
  parameter logic [15:0] PIN3        = 16'h4444,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        enter,
  input  logic        clear,
  input  logic        cancel,
  output logic [3:0]  status_code,
  output logic [1:0]  acct_idx,
  output logic [15:0] entry_value,
  output logic [2:0]  digit_cnt,
  output logic [2:0]  tries_left
);

  typedef enum logic [1:0] {S_ACCT, S_PIN, S_AUTH, S_LOCK} state_t;

  localparam logic [3:0]  ST_IDLE       = 4'd0;
  localparam logic [3:0]  ST_ACCT_ENTRY = 4'd1;
  localparam logic [3:0]  ST_ACCT_OK    = 4'd2;
  localparam logic [3:0]  ST_ACCT_BAD   = 4'd3;
  localparam logic [3:0]  ST_AUTH_OK    = 4'd4;
  localparam logic [3:0]  ST_PIN_BAD    = 4'd5;
  localparam logic [3:0]  ST_LOCKED     = 4'd6;
  localparam logic [2:0]  TRIES_INIT    = 3'(MAX_TRIES);
  localparam logic [31:0] LOCK_LOAD     = 32'(LOCK_CYCLES - 1);

  state_t      state;
  logic [31:0] lock_cnt;
  logic        acct_hit;
  logic [1:0]  acct_hit_idx;
  logic [15:0] pin_exp;
  logic        digit_ok;
  logic        entry_full;

  // Lowest index wins when the table holds duplicate account numbers.
  always_comb begin
    acct_hit     = 1'b1;
    acct_hit_idx = 2'd0;
    if (entry_value == ACCT0)      acct_hit_idx = 2'd0;
    else if (entry_value == ACCT1) acct_hit_idx = 2'd1;
    else if (entry_value == ACCT2) acct_hit_idx = 2'd2;
    else if (entry_value == ACCT3) acct_hit_idx = 2'd3;
    else                           acct_hit     = 1'b0;
  end

  always_comb begin
    pin_exp = PIN0;
    case (acct_idx)
      2'd1:    pin_exp = PIN1;
      2'd2:    pin_exp = PIN2;
      2'd3:    pin_exp = PIN3;
      default: pin_exp = PIN0;
    endcase
  end

  assign entry_full = (digit_cnt == 3'd4);
  assign digit_ok   = digit_valid && (digit <= 4'd9) && !entry_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_ACCT;
      status_code <= ST_IDLE;
      acct_idx    <= 2'd0;
      entry_value <= 16'd0;
      digit_cnt   <= 3'd0;
      tries_left  <= TRIES_INIT;
      lock_cnt    <= 32'd0;
    end else begin
      case (state)
        S_LOCK: begin
          if (lock_cnt == 32'd0) begin
            state       <= S_ACCT;
            status_code <= ST_IDLE;
            tries_left  <= TRIES_INIT;
            acct_idx    <= 2'd0;
          end else begin
            lock_cnt <= lock_cnt - 32'd1;
          end
        end
        S_AUTH: begin
          if (cancel) begin
            state       <= S_ACCT;
            status_code <= ST_IDLE;
          end
        end
        default: begin
          if (cancel) begin
            state       <= S_ACCT;
            status_code <= ST_IDLE;
            entry_value <= 16'd0;
            digit_cnt   <= 3'd0;
            acct_idx    <= 2'd0;
            tries_left  <= TRIES_INIT;
          end else if (enter) begin
            if (entry_full) begin
              entry_value <= 16'd0;
              digit_cnt   <= 3'd0;
              if (state == S_ACCT) begin
                if (acct_hit) begin
                  acct_idx    <= acct_hit_idx;
                  state       <= S_PIN;
                  status_code <= ST_ACCT_OK;
                  tries_left  <= TRIES_INIT;
                end else begin
                  status_code <= ST_ACCT_BAD;
                end
              end else if (entry_value == pin_exp) begin
                state       <= S_AUTH;
                status_code <= ST_AUTH_OK;
              end else if (tries_left > 3'd1) begin
                tries_left  <= tries_left - 3'd1;
                status_code <= ST_PIN_BAD;
              end else begin
                tries_left  <= 3'd0;
                state       <= S_LOCK;
                status_code <= ST_LOCKED;
                lock_cnt    <= LOCK_LOAD;
              end
            end
          end else if (clear) begin
            entry_value <= 16'd0;
            digit_cnt   <= 3'd0;
          end else if (digit_ok) begin
            entry_value <= {entry_value[11:0], digit};
            digit_cnt   <= digit_cnt + 3'd1;
            // Only a fresh session announces entry; a standing ACCT_BAD persists.
            if (state == S_ACCT && status_code == ST_IDLE)
              status_code <= ST_ACCT_ENTRY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_verifier.sv
// Bench for pin_verifier: directed scenarios with literal expectations plus randomized sessions checked every cycle against a queue-based model.
module tb_pin_verifier;

  localparam int MAX_TRIES = 3;
  localparam int LOCK      = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        digit_valid, enter, clear, cancel;
  logic [3:0]  digit;
  logic [3:0]  status_code;
  logic [1:0]  acct_idx;
  logic [15:0] entry_value;
  logic [2:0]  digit_cnt;
  logic [2:0]  tries_left;

  int n_checks = 0;
  int n_err    = 0;

  int accts[4] = '{1234, 2345, 3456, 4567};
  int pins[4]  = '{1111, 2222, 3333, 4444};

  // Model: mode 0 account entry, 1 PIN entry, 2 authenticated, 3 locked out.
  int m_mode, m_stat, m_acct, m_tries, m_lock_left;
  int m_digits[$];

  pin_verifier #(.LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
    .enter(enter), .clear(clear), .cancel(cancel), .status_code(status_code),
    .acct_idx(acct_idx), .entry_value(entry_value), .digit_cnt(digit_cnt),
    .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_stat = 0; m_acct = 0; m_tries = MAX_TRIES; m_lock_left = 0;
    m_digits.delete();
  endtask

  task automatic model_step();
    int val;
    int hit;
    if (m_mode == 3) begin
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_mode = 0; m_stat = 0; m_tries = MAX_TRIES; m_acct = 0;
      end
    end else if (cancel) begin
      if (m_mode == 2) begin
        m_mode = 0; m_stat = 0;
      end else begin
        model_reset();
      end
    end else if (m_mode == 2) begin
      // authenticated: only cancel matters
    end else if (enter) begin
      if (m_digits.size() == 4) begin
        val = 0;
        foreach (m_digits[i]) val = val * 10 + m_digits[i];
        m_digits.delete();
        if (m_mode == 0) begin
          hit = -1;
          for (int i = 3; i >= 0; i--) if (val == accts[i]) hit = i;
          if (hit >= 0) begin
            m_acct = hit; m_mode = 1; m_stat = 2; m_tries = MAX_TRIES;
          end else begin
            m_stat = 3;
          end
        end else if (val == pins[m_acct]) begin
          m_mode = 2; m_stat = 4;
        end else begin
          m_tries--;
          if (m_tries == 0) begin
            m_mode = 3; m_stat = 6; m_lock_left = LOCK;
          end else begin
            m_stat = 5;
          end
        end
      end
    end else if (clear) begin
      m_digits.delete();
    end else if (digit_valid && digit <= 4'd9 && m_digits.size() < 4) begin
      m_digits.push_back(int'(digit));
      if (m_mode == 0 && m_stat == 0) m_stat = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    int bcd;
    if (rst_n === 1'b1) begin
      bcd = 0;
      foreach (m_digits[i]) bcd = bcd * 16 + m_digits[i];
      chk("model_status", int'(status_code), m_stat);
      chk("model_entry", int'(entry_value), bcd);
      chk("model_digit_cnt", int'(digit_cnt), m_digits.size());
      chk("model_tries", int'(tries_left), m_tries);
      if (m_stat == 2 || m_stat == 4 || m_stat == 5)
        chk("model_acct_idx", int'(acct_idx), m_acct);
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit cv, input bit en, input bit cl, input bit dv, input logic [3:0] d);
    cancel = cv; enter = en; clear = cl; digit_valid = dv; digit = d;
    @(posedge clk);
    #1;
    cancel = 1'b0; enter = 1'b0; clear = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    @(negedge clk);
  endtask

  task automatic key(input int d);
    step(0, 0, 0, 1, 4'(d));
  endtask

  task automatic type_num(input int n);
    key((n / 1000) % 10); key((n / 100) % 10); key((n / 10) % 10); key(n % 10);
  endtask

  task automatic enter_num(input int n);
    type_num(n);
    step(0, 1, 0, 0, 4'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_status"}, int'(status_code), 0);
    chk({tag, "_entry"}, int'(entry_value), 0);
    chk({tag, "_cnt"}, int'(digit_cnt), 0);
    chk({tag, "_tries"}, int'(tries_left), 3);
    chk({tag, "_acct"}, int'(acct_idx), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cancel = 1'b0; enter = 1'b0; clear = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    @(negedge clk); @(negedge clk);
    check_reset_vals("reset");
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Account 1234 accepted
    key(1);
    chk("first_digit_status", int'(status_code), 1);
    key(2); key(3); key(4);
    chk("acct_entry_value", int'(entry_value), 16'h1234);
    step(0, 1, 0, 0, 4'd0);
    chk("acct_ok_status", int'(status_code), 2);
    chk("acct_ok_idx", int'(acct_idx), 0);
    chk("acct_ok_entry", int'(entry_value), 0);
    chk("acct_ok_tries", int'(tries_left), 3);
    step(1, 0, 0, 0, 4'd0);
    chk("cancel_status", int'(status_code), 0);

    // Account 2345 with PIN 2222
    enter_num(2345);
    enter_num(2222);
    chk("auth_status", int'(status_code), 4);
    chk("auth_idx", int'(acct_idx), 1);
    step(0, 0, 0, 1, 4'd7);
    chk("auth_digit_ignored", int'(digit_cnt), 0);
    step(1, 0, 0, 0, 4'd0);
    chk("auth_cancel_status", int'(status_code), 0);

    // Bad account, then short entry is ignored
    enter_num(9999);
    chk("acct_bad_status", int'(status_code), 3);
    key(1); key(2); key(3);
    step(0, 1, 0, 0, 4'd0);
    chk("short_enter_status", int'(status_code), 3);
    chk("short_enter_cnt", int'(digit_cnt), 3);
    step(1, 0, 0, 0, 4'd0);

    // Three wrong PINs lock out for exactly LOCK cycles
    enter_num(1234);
    enter_num(0);
    chk("wrong1_status", int'(status_code), 5);
    chk("wrong1_tries", int'(tries_left), 2);
    key(1);
    chk("pin_digit_status", int'(status_code), 5);
    step(0, 0, 1, 0, 4'd0);
    enter_num(0);
    chk("wrong2_status", int'(status_code), 5);
    chk("wrong2_tries", int'(tries_left), 1);
    enter_num(0);
    chk("locked_status", int'(status_code), 6);
    chk("locked_tries", int'(tries_left), 0);
    for (int i = 0; i < LOCK - 1; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1, 4'($urandom_range(0, 9)));
      chk("lock_hold_status", int'(status_code), 6);
    end
    step(0, 0, 0, 0, 4'd0);
    chk("lock_release_status", int'(status_code), 0);
    chk("lock_release_tries", int'(tries_left), 3);

    // Overflow digits and out-of-range digit dropped; enter beats clear
    type_num(1234);
    key(5); key(12);
    chk("overflow_entry", int'(entry_value), 16'h1234);
    chk("overflow_cnt", int'(digit_cnt), 4);
    step(0, 1, 1, 0, 4'd0);
    chk("enter_beats_clear", int'(status_code), 2);
    step(1, 1, 0, 0, 4'd0);
    chk("cancel_beats_enter", int'(status_code), 0);

    // Async reset during lockout
    enter_num(1234);
    enter_num(0); enter_num(0); enter_num(0);
    step(0, 0, 0, 0, 4'd0); step(0, 0, 0, 0, 4'd0);
    chk("pre_reset_locked", int'(status_code), 6);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    enter_num(4567);
    enter_num(4444);
    chk("fresh_auth_status", int'(status_code), 4);
    chk("fresh_auth_idx", int'(acct_idx), 3);
    step(1, 0, 0, 0, 4'd0);

    // Randomized sessions
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 6))
        0:       enter_num(accts[$urandom_range(0, 3)]);
        1:       enter_num(pins[$urandom_range(0, 3)]);
        2:       enter_num(int'($urandom_range(0, 9999)));
        3:       step(1, 0, 0, 0, 4'd0);
        default: step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 5) == 0),
                      1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pin_verifier.md
Name: pin_verifier

Overview:
- Upstream front end of the ATM controller: collects keypad digits for a 4-digit account number and then a 4-digit PIN.
- Checks each against a small parameterised account table and drives the 4-bit status_code consumed by the ATM FSM.
- Enforces a retry limit with a timed lockout.
- Exposes the digits typed so far so the display stage can echo them.

Parameters:
- ACCT0, 16'h1234, account 0 number, 4 BCD digits
- ACCT1, 16'h2345, account 1 number
- ACCT2, 16'h3456, account 2 number
- ACCT3, 16'h4567, account 3 number
- PIN0, 16'h1111, PIN for account 0
- PIN1, 16'h2222, PIN for account 1
- PIN2, 16'h3333, PIN for account 2
- PIN3, 16'h4444, PIN for account 3
- MAX_TRIES, 3, consecutive wrong PINs that trigger lockout (1..7)
- LOCK_CYCLES, 100000000, lockout duration in clk cycles (fits 32 bits)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- digit_valid  in  1  single-cycle strobe: digit is valid
- digit  in  4  BCD keypad digit
- enter  in  1  single-cycle strobe: submit current entry
- clear  in  1  single-cycle strobe: discard current entry
- cancel  in  1  single-cycle strobe: abort session / log out
- status_code  out  4  registered status to ATM FSM
- acct_idx  out  2  index of matched account, valid while status_code is 2, 4 or 5
- entry_value  out  16  digits entered so far, right-justified BCD, for display
- digit_cnt  out  3  number of digits entered (0..4)
- tries_left  out  3  remaining PIN attempts

Behaviour:
- Reset state (asynchronous, active-low):
  - state = S_ACCT, status_code = 0, acct_idx = 0, entry_value = 0, digit_cnt = 0, tries_left = MAX_TRIES, lock counter = 0.
- All outputs are registered; every response appears on the first clk edge after the strobe is sampled (1-cycle latency).
- Strobes are debounced single-cycle pulses from upstream.
- Same-cycle priority: cancel > enter > clear > digit_valid. Only the highest-priority strobe acts; the others are dropped.
- Status codes:
  - 0 IDLE: awaiting account
  - 1 ACCT_ENTRY: account digits in progress
  - 2 ACCT_OK: awaiting PIN
  - 3 ACCT_BAD
  - 4 AUTH_OK
  - 5 PIN_BAD
  - 6 LOCKED
  - 7..15 unused, never driven
- Digit entry (S_ACCT, S_PIN only):
  - On digit_valid with digit <= 9 and digit_cnt < 4: entry_value <= {entry_value[11:0], digit}, digit_cnt++.
  - Digits > 9, and a 5th or later digit, are ignored.
  - In S_ACCT the first accepted digit sets status_code to 1.
  - In S_PIN, status_code stays 2, or stays 5 after a wrong PIN, until the next enter.
- clear: entry_value <= 0, digit_cnt <= 0. Status and state are unchanged.
- enter with digit_cnt < 4: ignored.
- S_ACCT, enter with 4 digits:
  - Compare entry_value against ACCT0..3; lowest index wins on duplicates.
  - Match: acct_idx <= index, state <= S_PIN, status_code <= 2, tries_left <= MAX_TRIES.
  - No match: status_code <= 3, stay in S_ACCT.
  - Entry is cleared in both cases.
- S_PIN, enter with 4 digits:
  - Compare entry_value against PIN[acct_idx]; entry is cleared.
  - Match: state <= S_AUTH, status_code <= 4.
  - Mismatch with tries_left > 1: tries_left--, status_code <= 5.
  - Mismatch with tries_left == 1: tries_left <= 0, state <= S_LOCK, status_code <= 6, lock counter <= LOCK_CYCLES-1.
- S_AUTH: digit_valid, enter and clear are ignored. cancel -> S_ACCT, status_code 0.
- cancel in S_ACCT or S_PIN: -> S_ACCT, status_code 0, entry cleared, acct_idx 0, tries_left MAX_TRIES.
- S_LOCK:
  - All strobes, including cancel, are ignored. Lock counter decrements every cycle.
  - In the cycle the counter is 0: -> S_ACCT, status_code 0, tries_left MAX_TRIES, acct_idx 0.
  - Lockout lasts exactly LOCK_CYCLES cycles.
- Reset asserted mid-operation, including during lockout: immediate return to reset values, and the lockout is abandoned.

Test Plan:
- Reset, then digits 1,2,3,4 and enter -> status_code 1 after the first digit; 2 after enter with acct_idx 0, entry_value 0, tries_left 3.
- Account 2345, then PIN 2,2,2,2 and enter -> status_code 4, acct_idx 1. Then cancel -> status_code 0.
- Account 9999 and enter -> status_code 3, state S_ACCT. Then a 3-digit entry plus enter is ignored, with status_code still 3 and digit_cnt 3.
- Account 1234, then PIN 0000 three times with LOCK_CYCLES=10:
  - After each of the first two wrong PINs -> status_code 5, with tries_left 2 then 1.
  - After the third -> status_code 6; digits and cancel are ignored; status_code returns to 0 exactly 10 cycles later.
- Digits 1,2,3,4,5 and digit 12 -> entry_value 16'h1234, digit_cnt 4. Same-cycle clear and enter -> enter wins.
- rst_n pulsed low mid-lockout -> all outputs at reset values asynchronously. Then a fresh login to account 3 with PIN 4444 succeeds.
